// File: rtl/axil_master.sv
// axil_master: single-outstanding AXI-Lite master behind a cmd/rsp handshake.
// Optional feature macro AXIL_MASTER_ALIGN_CHECK_EN answers misaligned commands with SLVERR.
module axil_master #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_we,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic [STRB_WIDTH-1:0] cmd_wstrb,

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_we,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]            rsp_resp,

    output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
    output logic [2:0]            m_axil_awprot,
    output logic                  m_axil_awvalid,
    input  logic                  m_axil_awready,
    output logic [DATA_WIDTH-1:0] m_axil_wdata,
    output logic [STRB_WIDTH-1:0] m_axil_wstrb,
    output logic                  m_axil_wvalid,
    input  logic                  m_axil_wready,
    input  logic [1:0]            m_axil_bresp,
    input  logic                  m_axil_bvalid,
    output logic                  m_axil_bready,
    output logic [ADDR_WIDTH-1:0] m_axil_araddr,
    output logic [2:0]            m_axil_arprot,
    output logic                  m_axil_arvalid,
    input  logic                  m_axil_arready,
    input  logic [DATA_WIDTH-1:0] m_axil_rdata,
    input  logic [1:0]            m_axil_rresp,
    input  logic                  m_axil_rvalid,
    output logic                  m_axil_rready
);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        WRESP,
        READ,
        RDATA,
        RESP
    } state_t;

    state_t state_q;
    state_t state_n;

    logic                  aw_done_q;
    logic                  aw_done_n;
    logic                  w_done_q;
    logic                  w_done_n;
    logic                  accept;
    logic                  misaligned;

    logic                  cap;
    logic                  cap_we;
    logic [DATA_WIDTH-1:0] cap_rdata;
    logic [1:0]            cap_resp;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_WIDTH-1:0] wstrb_q;
    logic                  we_q;

    assign accept = cmd_valid && cmd_ready;

`ifdef AXIL_MASTER_ALIGN_CHECK_EN
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(STRB_WIDTH - 1);
    assign misaligned = (cmd_addr & ALIGN_MASK) != '0;
`else
    assign misaligned = 1'b0;
`endif

    assign m_axil_awaddr = addr_q;
    assign m_axil_araddr = addr_q;
    assign m_axil_wdata  = wdata_q;
    assign m_axil_wstrb  = wstrb_q;
    assign m_axil_awprot = 3'b000;
    assign m_axil_arprot = 3'b000;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_n;
            aw_done_q <= aw_done_n;
            w_done_q  <= w_done_n;
        end
    end

    // AW and W retire independently; WRESP waits for both recorded handshakes
    always_comb begin
        state_n   = state_q;
        aw_done_n = aw_done_q;
        w_done_n  = w_done_q;
        cap       = 1'b0;
        cap_we    = we_q;
        cap_rdata = '0;
        cap_resp  = 2'b00;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    aw_done_n = 1'b0;
                    w_done_n  = 1'b0;
                    if (misaligned) begin
                        state_n  = RESP;
                        cap      = 1'b1;
                        cap_we   = cmd_we;
                        cap_resp = 2'b10;
                    end else begin
                        state_n = cmd_we ? WRITE : READ;
                    end
                end
            end
            WRITE: begin
                if (m_axil_awvalid && m_axil_awready) aw_done_n = 1'b1;
                if (m_axil_wvalid && m_axil_wready) w_done_n = 1'b1;
                if (aw_done_q && w_done_q) state_n = WRESP;
            end
            WRESP: begin
                if (m_axil_bvalid && m_axil_bready) begin
                    state_n  = RESP;
                    cap      = 1'b1;
                    cap_resp = m_axil_bresp;
                end
            end
            READ: begin
                if (m_axil_arvalid && m_axil_arready) state_n = RDATA;
            end
            RDATA: begin
                if (m_axil_rvalid && m_axil_rready) begin
                    state_n   = RESP;
                    cap       = 1'b1;
                    cap_rdata = m_axil_rdata;
                    cap_resp  = m_axil_rresp;
                end
            end
            RESP: begin
                if (rsp_valid && rsp_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Handshake outputs are flops loaded from the next state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmd_ready      <= 1'b1;
            m_axil_awvalid <= 1'b0;
            m_axil_wvalid  <= 1'b0;
            m_axil_bready  <= 1'b0;
            m_axil_arvalid <= 1'b0;
            m_axil_rready  <= 1'b0;
            rsp_valid      <= 1'b0;
            rsp_we         <= 1'b0;
            rsp_rdata      <= '0;
            rsp_resp       <= 2'b00;
            addr_q         <= '0;
            wdata_q        <= '0;
            wstrb_q        <= '0;
            we_q           <= 1'b0;
        end else begin
            cmd_ready      <= state_n == IDLE;
            m_axil_awvalid <= (state_n == WRITE) && !aw_done_n;
            m_axil_wvalid  <= (state_n == WRITE) && !w_done_n;
            m_axil_bready  <= state_n == WRESP;
            m_axil_arvalid <= state_n == READ;
            m_axil_rready  <= state_n == RDATA;
            rsp_valid      <= state_n == RESP;
            if (accept) begin
                addr_q  <= cmd_addr;
                wdata_q <= cmd_wdata;
                wstrb_q <= cmd_wstrb;
                we_q    <= cmd_we;
            end
            if (cap) begin
                rsp_we    <= cap_we;
                rsp_rdata <= cap_rdata;
                rsp_resp  <= cap_resp;
            end
        end
    end

endmodule

// File: tb/tb_axil_master.sv
// tb_axil_master: directed and randomized checks of axil_master against a
// delay-configurable AXI-Lite memory slave and a word-array reference model.
`timescale 1ns/1ps
module tb_axil_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [15:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic        rsp_we;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;

    logic [15:0] m_axil_awaddr;
    logic [2:0]  m_axil_awprot;
    logic        m_axil_awvalid;
    logic        m_axil_awready;
    logic [31:0] m_axil_wdata;
    logic [3:0]  m_axil_wstrb;
    logic        m_axil_wvalid;
    logic        m_axil_wready;
    logic [1:0]  m_axil_bresp;
    logic        m_axil_bvalid;
    logic        m_axil_bready;
    logic [15:0] m_axil_araddr;
    logic [2:0]  m_axil_arprot;
    logic        m_axil_arvalid;
    logic        m_axil_arready;
    logic [31:0] m_axil_rdata;
    logic [1:0]  m_axil_rresp;
    logic        m_axil_rvalid;
    logic        m_axil_rready;

    always #5 clk = ~clk;

    axil_master dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_we         (cmd_we),
        .cmd_addr       (cmd_addr),
        .cmd_wdata      (cmd_wdata),
        .cmd_wstrb      (cmd_wstrb),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_we         (rsp_we),
        .rsp_rdata      (rsp_rdata),
        .rsp_resp       (rsp_resp),
        .m_axil_awaddr  (m_axil_awaddr),
        .m_axil_awprot  (m_axil_awprot),
        .m_axil_awvalid (m_axil_awvalid),
        .m_axil_awready (m_axil_awready),
        .m_axil_wdata   (m_axil_wdata),
        .m_axil_wstrb   (m_axil_wstrb),
        .m_axil_wvalid  (m_axil_wvalid),
        .m_axil_wready  (m_axil_wready),
        .m_axil_bresp   (m_axil_bresp),
        .m_axil_bvalid  (m_axil_bvalid),
        .m_axil_bready  (m_axil_bready),
        .m_axil_araddr  (m_axil_araddr),
        .m_axil_arprot  (m_axil_arprot),
        .m_axil_arvalid (m_axil_arvalid),
        .m_axil_arready (m_axil_arready),
        .m_axil_rdata   (m_axil_rdata),
        .m_axil_rresp   (m_axil_rresp),
        .m_axil_rvalid  (m_axil_rvalid),
        .m_axil_rready  (m_axil_rready)
    );

    int vectors = 0;
    int miscompares = 0;

    int aw_dly = 0;
    int w_dly = 0;
    int ar_dly = 0;
    int b_dly = 0;
    int r_dly = 0;
    logic [1:0] bresp_cfg = 2'b00;
    logic [1:0] rresp_cfg = 2'b00;

    // Slave: memory with per-channel ready/valid delays
    logic [31:0] smem [256];
    logic        mem_cleared = 1'b0;
    int          aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    logic        saw_aw, saw_w, saw_ar;
    logic [15:0] s_awaddr, s_araddr;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;

    assign m_axil_awready = m_axil_awvalid && (aw_cnt >= aw_dly);
    assign m_axil_wready  = m_axil_wvalid && (w_cnt >= w_dly);
    assign m_axil_arready = m_axil_arvalid && (ar_cnt >= ar_dly);
    assign m_axil_bvalid  = saw_aw && saw_w && (b_cnt >= b_dly);
    assign m_axil_bresp   = bresp_cfg;
    assign m_axil_rvalid  = saw_ar && (r_cnt >= r_dly);
    assign m_axil_rdata   = smem[s_araddr[9:2]];
    assign m_axil_rresp   = rresp_cfg;

    always @(posedge clk) begin
        if (!mem_cleared) begin
            for (int i = 0; i < 256; i++) smem[i] <= '0;
            mem_cleared <= 1'b1;
        end
        if (!rst_n) begin
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_cnt <= 0; r_cnt <= 0;
            saw_aw <= 1'b0; saw_w <= 1'b0; saw_ar <= 1'b0;
            s_awaddr <= '0; s_araddr <= '0; s_wdata <= '0; s_wstrb <= '0;
        end else begin
            if (m_axil_awvalid && !m_axil_awready) aw_cnt <= aw_cnt + 1;
            if (m_axil_awvalid && m_axil_awready) begin
                aw_cnt <= 0; saw_aw <= 1'b1; s_awaddr <= m_axil_awaddr;
            end
            if (m_axil_wvalid && !m_axil_wready) w_cnt <= w_cnt + 1;
            if (m_axil_wvalid && m_axil_wready) begin
                w_cnt <= 0; saw_w <= 1'b1;
                s_wdata <= m_axil_wdata; s_wstrb <= m_axil_wstrb;
            end
            if (saw_aw && saw_w && !m_axil_bvalid) b_cnt <= b_cnt + 1;
            if (m_axil_bvalid && m_axil_bready) begin
                for (int i = 0; i < 4; i++)
                    if (s_wstrb[i]) smem[s_awaddr[9:2]][8*i +: 8] <= s_wdata[8*i +: 8];
                saw_aw <= 1'b0; saw_w <= 1'b0; b_cnt <= 0;
            end
            if (m_axil_arvalid && !m_axil_arready) ar_cnt <= ar_cnt + 1;
            if (m_axil_arvalid && m_axil_arready) begin
                ar_cnt <= 0; saw_ar <= 1'b1; s_araddr <= m_axil_araddr;
            end
            if (saw_ar && !m_axil_rvalid) r_cnt <= r_cnt + 1;
            if (m_axil_rvalid && m_axil_rready) begin
                saw_ar <= 1'b0; r_cnt <= 0;
            end
        end
    end

    // Bus monitor: valid-cycle counts, beat count, ordering and prot rules
    int   aw_cyc = 0, w_cyc = 0, ar_cyc = 0, beats = 0;
    int   bready_viol = 0, prot_viol = 0, rsp_seen = 0;
    logic mon_aw = 1'b0, mon_w = 1'b0;

    always @(posedge clk) begin
        if (m_axil_awvalid) aw_cyc++;
        if (m_axil_wvalid) w_cyc++;
        if (m_axil_arvalid) ar_cyc++;
        if (rsp_valid) rsp_seen++;
        if (m_axil_awvalid && m_axil_awready) beats++;
        if (m_axil_wvalid && m_axil_wready) beats++;
        if (m_axil_arvalid && m_axil_arready) beats++;
        if (m_axil_bvalid && m_axil_bready) beats++;
        if (m_axil_rvalid && m_axil_rready) beats++;
        if ((m_axil_awvalid || m_axil_arvalid) && (m_axil_awprot != 3'b000 || m_axil_arprot != 3'b000))
            prot_viol++;
        if (m_axil_bready && !(mon_aw && mon_w)) bready_viol++;
        if (!rst_n) begin
            mon_aw = 1'b0; mon_w = 1'b0;
        end else begin
            if (m_axil_awvalid && m_axil_awready) mon_aw = 1'b1;
            if (m_axil_wvalid && m_axil_wready) mon_w = 1'b1;
            if (m_axil_bvalid && m_axil_bready) begin
                mon_aw = 1'b0; mon_w = 1'b0;
            end
        end
    end

    logic [31:0] model [256];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One command end to end; lat counts cycles from acceptance to rsp handshake inclusive
    task automatic run_cmd(input logic we, input logic [15:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int hold, output int lat);
        int          n;
        int          cyc;
        int          left;
        int          aw0, w0, ar0;
        logic        seen;
        logic        bad;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;
        logic        h_we;
        logic [31:0] h_rdata;
        logic [1:0]  h_resp;
        bad = 1'b0;
`ifdef AXIL_MASTER_ALIGN_CHECK_EN
        bad = addr[1:0] != 2'b00;
`endif
        exp_rdata = '0;
        if (bad) exp_resp = 2'b10;
        else if (we) exp_resp = bresp_cfg;
        else begin
            exp_resp = rresp_cfg;
            exp_rdata = model[addr[9:2]];
        end
        h_we = 1'b0; h_rdata = '0; h_resp = '0;
        aw0 = aw_cyc; w0 = w_cyc; ar0 = ar_cyc;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr;
        cmd_wdata = data; cmd_wstrb = strb;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_ready_wait", 64'(n < 50), 64'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_we = 1'($urandom); cmd_addr = 16'($urandom);
        cmd_wdata = $urandom; cmd_wstrb = 4'($urandom);
        cyc = 1; left = hold; seen = 1'b0; lat = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            cyc++;
            if (rsp_valid) begin
                if (!seen) begin
                    seen = 1'b1; h_we = rsp_we; h_rdata = rsp_rdata; h_resp = rsp_resp;
                end else begin
                    chk("rsp_stable", 64'({rsp_we, rsp_resp, rsp_rdata}), 64'({h_we, h_resp, h_rdata}));
                end
                chk("cmd_ready_busy", 64'(cmd_ready), 64'd0);
                if (left == 0) begin
                    rsp_ready = 1'b1;
                    lat = cyc;
                    break;
                end
                left--;
            end
        end
        chk("rsp_arrived", 64'(lat != 0), 64'd1);
        if (lat != 0) begin
            @(posedge clk);
            #1;
            rsp_ready = 1'b0;
            chk("rsp_we", 64'(h_we), 64'(we));
            chk("rsp_rdata", 64'(h_rdata), 64'(exp_rdata));
            chk("rsp_resp", 64'(h_resp), 64'(exp_resp));
            if (bad) begin
                chk("bus_quiet", 64'(aw_cyc - aw0 + w_cyc - w0 + ar_cyc - ar0), 64'd0);
            end else if (we) begin
                chk("aw_cycles", 64'(aw_cyc - aw0), 64'(aw_dly + 1));
                chk("w_cycles", 64'(w_cyc - w0), 64'(w_dly + 1));
                chk("ar_none", 64'(ar_cyc - ar0), 64'd0);
                for (int i = 0; i < 4; i++)
                    if (strb[i]) model[addr[9:2]][8*i +: 8] = data[8*i +: 8];
            end else begin
                chk("ar_cycles", 64'(ar_cyc - ar0), 64'(ar_dly + 1));
                chk("aw_none", 64'(aw_cyc - aw0 + w_cyc - w0), 64'd0);
            end
            @(negedge clk);
            chk("cmd_ready_after", 64'(cmd_ready), 64'd1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        int          n;
        int          beats0;
        int          rsp0;
        logic        we;
        logic [15:0] addr;
        for (int i = 0; i < 256; i++) model[i] = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_valids", 64'({m_axil_awvalid, m_axil_wvalid, m_axil_bready, m_axil_arvalid,
                                 m_axil_rready, rsp_valid}), 64'd0);
        chk("reset_rsp", 64'({rsp_we, rsp_resp, rsp_rdata}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_cmd_ready", 64'(cmd_ready), 64'd1);

        // Back-to-back always-ready write then read
        run_cmd(1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, 0, lat);
        chk("wr_latency", 64'(lat), 64'd5);
        run_cmd(1'b0, 16'h0010, 32'h0, 4'h0, 0, lat);
        chk("rd_latency", 64'(lat), 64'd4);

        // AW accepted late, W immediately
        aw_dly = 3;
        run_cmd(1'b1, 16'h0020, 32'hA5A5_0F0F, 4'h5, 0, lat);
        aw_dly = 0;
        chk("bready_order", 64'(bready_viol), 64'd0);

        // Error response held back by a stalled consumer
        rresp_cfg = 2'b11;
        run_cmd(1'b0, 16'h0010, 32'h0, 4'h0, 4, lat);
        chk("held_rd_latency", 64'(lat), 64'd8);
        rresp_cfg = 2'b00;

        // Reset while waiting for B
        b_dly = 40;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 16'h0040;
        cmd_wdata = 32'h1234_5678; cmd_wstrb = 4'hF;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        n = 0;
        while (!m_axil_bready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("wresp_reached", 64'(m_axil_bready), 64'd1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midreset_quiet", 64'({m_axil_awvalid, m_axil_wvalid, m_axil_bready, m_axil_arvalid,
                                   m_axil_rready, rsp_valid}), 64'd0);
        beats0 = beats;
        rsp0 = rsp_seen;
        rst_n = 1'b1;
        b_dly = 0;
        @(negedge clk);
        chk("release_cmd_ready", 64'(cmd_ready), 64'd1);
        repeat (8) @(negedge clk);
        chk("abandoned_beats", 64'(beats - beats0), 64'd0);
        chk("abandoned_rsp", 64'(rsp_seen - rsp0), 64'd0);
        run_cmd(1'b0, 16'h0040, 32'h0, 4'h0, 0, lat);

        // Misaligned read
        run_cmd(1'b0, 16'h0012, 32'h0, 4'h0, 0, lat);
`ifndef AXIL_MASTER_ALIGN_CHECK_EN
        chk("misaligned_araddr", 64'(s_araddr), 64'h0012);
`endif

        // Randomized traffic with random delays and response codes
        for (int t = 0; t < 40; t++) begin
            aw_dly = int'($urandom_range(0, 3));
            w_dly = int'($urandom_range(0, 3));
            ar_dly = int'($urandom_range(0, 3));
            b_dly = int'($urandom_range(0, 3));
            r_dly = int'($urandom_range(0, 3));
            bresp_cfg = 2'($urandom);
            rresp_cfg = 2'($urandom);
            we = 1'($urandom);
            addr = {6'b0, 4'b0, 4'($urandom_range(0, 15)), 2'b00};
            if ($urandom_range(0, 3) == 0) addr[1:0] = 2'($urandom_range(1, 3));
            run_cmd(we, addr, $urandom, 4'($urandom), int'($urandom_range(0, 2)), lat);
        end

        chk("bready_order_final", 64'(bready_viol), 64'd0);
        chk("prot_zero", 64'(prot_viol), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
